mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the instruction-fetch stage (IF) and the memory-access stage (D) of the 16-bit pipelined processor.
- Sequences one memory transaction at a time and returns read data with single-cycle valid pulses.
- Generates per-stage stall signals.
- Honours pipeline flush by discarding in-flight fetch results.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MAX_D_STREAK, 4, consecutive D grants allowed while IF waits before IF is forced; range 1..15.
- TIMEOUT, 15, BUSY cycles without mem_ready before abort; 0 disables; range 0..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush from control unit.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle completion pulse.
- stall_if  out  1  combinational: if_req & ~if_valid.
- stall_mem  out  1  combinational: d_req & ~d_valid.
- bus_err  out  1  one-cycle pulse with valid on timeout.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  transaction done; sampled only while mem_req = 1.

Behaviour:
- Reset: state IDLE, streak = 0, timer = 0, drop = 0. All registered outputs 0, including rdata buses.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- Eligibility in IDLE:
  - IF is eligible when if_req & ~if_valid & ~flush.
  - D is eligible when d_req & ~d_valid.
- Priority: D wins when both are eligible, unless streak == MAX_D_STREAK, in which case IF wins.
- Streak counter:
  - Increments on a D grant while IF is eligible.
  - Clears on any IF grant, and on a D grant while IF is not eligible.
  - Saturates at MAX_D_STREAK.
- Grant at edge E0:
  - Register mem_addr, mem_we and mem_wdata from the winner; mem_we = 0 for IF.
  - Set mem_req = 1, clear timer, move to BUSY_x.
- BUSY_x with mem_ready = 1 at edge E1:
  - mem_req and mem_we go to 0, state returns to IDLE.
  - x_valid = 1 for exactly the following cycle.
  - x_rdata <= mem_rdata on reads; d_rdata is unchanged on stores.
- Minimum latency: req in cycle 0 → mem_req in cycle 1 → valid in cycle 2 (mem_ready in cycle 1).
- The same requester cannot be granted in its own valid cycle. The other requester can, so back-to-back IF/D alternation needs no idle cycle.
- Flush:
  - In BUSY_IF: set drop. The transaction still completes; if_valid and if_rdata update are suppressed.
  - drop clears on completion.
  - Flush in IDLE blocks IF eligibility that cycle.
  - D transactions are never affected by flush.
  - Flush coincident with mem_ready in BUSY_IF: result is dropped.
- Timeout (TIMEOUT > 0): the timer counts BUSY cycles. If the timer reaches TIMEOUT without mem_ready:
  - Deassert mem_req and return to IDLE.
  - Pulse x_valid and bus_err together; x_rdata <= 0 on reads.
  - A dropped fetch pulses neither signal.
- The requester must not change address or data while its req is high and valid is low. Behaviour under such a change is undefined.
- Reset mid-transaction aborts immediately; no valid is issued.

Decomposition:
- Shared package: arb_state_t enum (IDLE, BUSY_IF, BUSY_D) and a requester ID constant pair (REQ_IF = 0, REQ_D = 1).
- One natural sub-module: arb_priority_sel (combinational winner select plus streak update), leaving the FSM and timers in the top level.

Test Plan:
- Lone fetch: if_req, if_addr = 0x0010, mem_ready one cycle after mem_req, mem_rdata = 0xA5C3 → mem_addr = 0x0010, mem_we = 0; if_valid in cycle 2 with if_rdata = 0xA5C3; stall_if high in cycles 0–1.
- Contention: if_req and d_req both high with d_we = 1, d_addr = 0x0200, d_wdata = 0x1234, mem_ready after 2 cycles → D served first (mem_we = 1, mem_wdata = 0x1234), d_valid pulses, IF granted the next cycle.
- Starvation guard: if_req held high, d_req re-raised immediately after each d_valid, MAX_D_STREAK = 4 → exactly 4 D grants, then an IF grant, then D resumes.
- Flush: flush pulsed in the second cycle of BUSY_IF, mem_ready 3 cycles later → no if_valid, if_rdata unchanged; a subsequent fetch of 0x0040 returns normally.
- Timeout: TIMEOUT = 15, mem_ready never asserted on a D load → mem_req drops after 15 BUSY cycles; d_valid and bus_err pulse together with d_rdata = 0x0000.
- Reset mid-transaction: reset asserted during BUSY_D → mem_req = 0 and all outputs 0 asynchronously; no d_valid after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the IF/D memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    // Requester identifiers
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    // Widths of the D-streak counter and the BUSY timeout timer
    localparam int STREAK_W = 4;
    localparam int TIMER_W  = 8;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_priority_sel.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority_sel
// Description : Combinational winner select between IF and D, plus the
//               next value of the D-streak counter that bounds IF starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                if_elig_i,
    input  logic                d_elig_i,
    input  logic [STREAK_W-1:0] streak_q_i,
    output logic                grant_o,
    output logic                grant_id_o,
    output logic [STREAK_W-1:0] streak_d_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    // D normally wins; IF is forced once D has won MAX_D_STREAK times in a row
    always_comb begin
        grant_o    = 1'b0;
        grant_id_o = REQ_IF;
        streak_d_o = streak_q_i;
        if (d_elig_i && !(if_elig_i && (streak_q_i == STREAK_MAX))) begin
            grant_o    = 1'b1;
            grant_id_o = REQ_D;
            // Only a D win over a waiting IF extends the streak
            if (if_elig_i) begin
                streak_d_o = streak_q_i + STREAK_W'(1);
            end else begin
                streak_d_o = '0;
            end
        end else if (if_elig_i) begin
            grant_o    = 1'b1;
            grant_id_o = REQ_IF;
            streak_d_o = '0;
        end
    end

endmodule : arb_priority_sel
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch (IF) and data access (D). One transaction at a time,
//               single-cycle valid pulses, stall outputs, flush-drop of
//               in-flight fetches and a BUSY timeout with bus error.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    arb_state_t          state_q;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic                drop_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                if_valid_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                d_valid_q;
    logic                bus_err_q;

    logic if_elig;
    logic d_elig;
    logic grant;
    logic grant_id;
    logic timeout_hit;
    logic done;

    // A requester is never re-granted during its own valid cycle
    assign if_elig = (state_q == IDLE) & if_req_i & ~if_valid_q & ~flush_i;
    assign d_elig  = (state_q == IDLE) & d_req_i & ~d_valid_q;

    assign timer_d     = timer_q + TIMER_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (timer_d == TIMER_W'(TIMEOUT));
    assign done        = mem_ready_i | timeout_hit;

    arb_priority_sel #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_sel (
        .if_elig_i  (if_elig),
        .d_elig_i   (d_elig),
        .streak_q_i (streak_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .streak_d_o (streak_d)
    );

    // Transaction sequencer with registered memory-side and requester outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            timer_q     <= '0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    if (grant) begin
                        mem_req_q <= 1'b1;
                        timer_q   <= '0;
                        drop_q    <= 1'b0;
                        if (grant_id == REQ_D) begin
                            mem_addr_q  <= d_addr_i;
                            mem_we_q    <= d_we_i;
                            mem_wdata_q <= d_wdata_i;
                            state_q     <= BUSY_D;
                        end else begin
                            mem_addr_q <= if_addr_i;
                            mem_we_q   <= 1'b0;
                            state_q    <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF: begin
                    if (done) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        drop_q    <= 1'b0;
                        state_q   <= IDLE;
                        // A flush seen at any point, including this cycle, drops the result
                        if (!(drop_q || flush_i)) begin
                            if_valid_q <= 1'b1;
                            bus_err_q  <= ~mem_ready_i;
                            if_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        timer_q <= timer_d;
                        if (flush_i) begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                BUSY_D: begin
                    if (done) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                        d_valid_q <= 1'b1;
                        bus_err_q <= ~mem_ready_i;
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_if_o  = if_req_i & ~if_valid_q;
    assign stall_mem_o = d_req_i & ~d_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_valid_o   = d_valid_q;
    assign bus_err_o   = bus_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter: behavioural memory,
//               expected-response queues per requester, directed scenarios
//               and a randomized concurrent IF/D phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic        st;
    } exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_drv;
    logic        streak_mode;
    logic        flush;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] cyc    = 0;
    int          force_lat;

    logic [15:0] mem     [0:1023];
    logic [15:0] exp_mem [0:1023];
    logic [15:0] last_d;
    exp_t        if_q [$];
    exp_t        d_q  [$];
    grant_t      glog [$];

    // In the starvation scenario the pipeline flushes during every D valid cycle
    assign flush = flush_drv | (streak_mode & d_valid);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .MAX_D_STREAK (4),
        .TIMEOUT      (15)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata),
        .d_valid_o   (d_valid),
        .stall_if_o  (stall_if),
        .stall_mem_o (stall_mem),
        .bus_err_o   (bus_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    function automatic logic is_hole(input logic [15:0] a);
        return a[3:0] == 4'hF;
    endfunction

    // Behavioural memory: addresses ending in 0xF never answer
    int mcnt = 0;
    int mlat = 0;
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mcnt      = 0;
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
        end else begin
            if (mcnt == 0) mlat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            mcnt++;
            if (!is_hole(mem_addr) && mcnt > mlat) begin
                mem_ready = 1'b1;
                if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
                else        mem_rdata = mem[mem_addr[9:0]];
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: pops expectations on valid pulses, checks stalls, logs grants
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            chk("stall_if", 32'(stall_if), 32'(if_req & ~if_valid));
            chk("stall_mem", 32'(stall_mem), 32'(d_req & ~d_valid));
            if (if_valid) begin
                if (if_q.size() == 0) begin
                    chk("if_valid_unexpected", 32'(if_valid), 32'(0));
                end else begin
                    e = if_q.pop_front();
                    chk("if_rdata", 32'(if_rdata), 32'(e.rdata));
                    chk("if_bus_err", 32'(bus_err), 32'(e.err));
                end
            end
            if (d_valid) begin
                if (d_q.size() == 0) begin
                    chk("d_valid_unexpected", 32'(d_valid), 32'(0));
                end else begin
                    e = d_q.pop_front();
                    chk(e.st ? "d_rdata_store" : "d_rdata_load", 32'(d_rdata), 32'(e.rdata));
                    chk("d_bus_err", 32'(bus_err), 32'(e.err));
                end
            end
            if (bus_err && !if_valid && !d_valid)
                chk("bus_err_alone", 32'(bus_err), 32'(0));
            if (mem_req && !prev_req)
                glog.push_back('{cyc: cyc, we: mem_we, addr: mem_addr, wdata: mem_wdata});
        end
        prev_req = mem_req;
    end

    task automatic do_fetch(input logic [15:0] a);
        exp_t e;
        int   n;
        e.st    = 1'b0;
        e.err   = is_hole(a);
        e.rdata = is_hole(a) ? 16'h0 : exp_mem[a[9:0]];
        if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid && n < 300);
        if (!if_valid) begin
            chk("if_wait_bound", 32'(n), 32'(0));
            void'(if_q.pop_back());
        end
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        int   n;
        e.st  = we;
        e.err = is_hole(a);
        if (we) begin
            if (!is_hole(a)) exp_mem[a[9:0]] = wd;
            e.rdata = last_d;
        end else begin
            e.rdata = is_hole(a) ? 16'h0 : exp_mem[a[9:0]];
            last_d  = e.rdata;
        end
        d_q.push_back(e);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_valid && n < 300);
        if (!d_valid) begin
            chk("d_wait_bound", 32'(n), 32'(0));
            void'(d_q.pop_back());
        end
        d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          w;
        logic [15:0] saved;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = init_val(i);
            exp_mem[i] = init_val(i);
        end
        mem[16'h0010]     = 16'hA5C3;
        exp_mem[16'h0010] = 16'hA5C3;
        last_d      = 16'h0;
        force_lat   = -1;
        reset       = 1'b1;
        flush_drv   = 1'b0;
        streak_mode = 1'b0;
        if_req = 1'b0; if_addr = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        mem_ready = 1'b0; mem_rdata = 16'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_if_valid", 32'(if_valid), 32'(0));
        chk("rst_d_valid", 32'(d_valid), 32'(0));
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_d_rdata", 32'(d_rdata), 32'(0));
        chk("rst_bus_err", 32'(bus_err), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // Lone fetch at minimum latency
        force_lat = 0;
        fork
            do_fetch(16'h0010);
            begin
                #1;
                chk("lone_stall_c0", 32'(stall_if), 32'(1));
                chk("lone_req_c0", 32'(mem_req), 32'(0));
                @(negedge clk); #2;
                chk("lone_req_c1", 32'(mem_req), 32'(1));
                chk("lone_addr_c1", 32'(mem_addr), 32'h0010);
                chk("lone_we_c1", 32'(mem_we), 32'(0));
                chk("lone_stall_c1", 32'(stall_if), 32'(1));
                @(negedge clk); #2;
                chk("lone_valid_c2", 32'(if_valid), 32'(1));
            end
        join
        @(negedge clk);

        // Contention: D store served first, IF granted right after d_valid
        force_lat = 1;
        glog.delete();
        fork
            do_data(1'b1, 16'h0200, 16'h1234);
            do_fetch(16'h0020);
        join
        @(negedge clk);
        chk("cont_grants", 32'(glog.size()), 32'(2));
        if (glog.size() >= 2) begin
            chk("cont_first_we", 32'(glog[0].we), 32'(1));
            chk("cont_first_addr", 32'(glog[0].addr), 32'h0200);
            chk("cont_first_wdata", 32'(glog[0].wdata), 32'h1234);
            chk("cont_second_addr", 32'(glog[1].addr), 32'h0020);
            chk("cont_if_gap", glog[1].cyc - glog[0].cyc, 32'(3));
        end

        // Starvation guard: exactly four D grants, then IF, then D again
        force_lat   = -1;
        streak_mode = 1'b1;
        glog.delete();
        fork
            do_fetch(16'h0031);
            for (int k = 0; k < 6; k++) do_data(1'b0, 16'(16'h0100 + k * 2), 16'h0);
        join
        streak_mode = 1'b0;
        @(negedge clk);
        chk("streak_grants", 32'(glog.size()), 32'(7));
        if (glog.size() >= 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("streak_order_%0d", k), 32'(glog[k].addr >= 16'h0100),
                    32'(k != 4));
        end

        // Flush during BUSY_IF drops the fetch
        force_lat = 4;
        saved     = if_rdata;
        if_addr   = 16'h0030;
        if_req    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush_drv = 1'b1;
        if_req    = 1'b0;
        @(negedge clk);
        flush_drv = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #2;
            if (if_valid) cnt++;
        end
        chk("flush_no_valid", 32'(cnt), 32'(0));
        chk("flush_rdata_kept", 32'(if_rdata), 32'(saved));
        chk("flush_req_done", 32'(mem_req), 32'(0));
        @(negedge clk);
        force_lat = -1;
        do_fetch(16'h0040);

        // Timeout on a D load that never completes
        fork
            do_data(1'b0, 16'h01FF, 16'h0);
            begin
                cnt = 0;
                w   = 0;
                while (!mem_req && w < 50) begin @(negedge clk); #1; w++; end
                while (mem_req && cnt < 100) begin cnt++; @(negedge clk); #1; end
                chk("timeout_len", 32'(cnt), 32'(15));
            end
        join
        @(negedge clk);

        // Randomized concurrent traffic
        fork
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_fetch(16'($urandom_range(0, 255)));
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_data(1'($urandom_range(0, 1)), 16'(16'h0100 + $urandom_range(0, 511)),
                        16'($urandom));
            end
        join
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of BUSY_D
        d_we   = 1'b0;
        d_addr = 16'h02AF;
        d_req  = 1'b1;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("amid_mem_req", 32'(mem_req), 32'(0));
        chk("amid_mem_addr", 32'(mem_addr), 32'(0));
        chk("amid_d_valid", 32'(d_valid), 32'(0));
        chk("amid_d_rdata", 32'(d_rdata), 32'(0));
        chk("amid_if_rdata", 32'(if_rdata), 32'(0));
        d_req  = 1'b0;
        last_d = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); #2;
            if (d_valid) cnt++;
        end
        chk("amid_no_valid", 32'(cnt), 32'(0));

        chk("if_q_drained", 32'(if_q.size()), 32'(0));
        chk("d_q_drained", 32'(d_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
